// File: rtl/acc_datapath.sv
// Datapath of the 8-bit accumulator CPU: PC, IR, register file, ACC, ALU and carry flag.
// Every state element moves only under the controller's strobes; all-zero strobes is HALT.
module acc_datapath #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              SelPC,
    input  logic              LoadPC,
    input  logic              LoadReg,
    input  logic              DumpReg,
    input  logic              LoadAcc,
    input  logic [1:0]        SelAcc,
    input  logic [3:0]        SelALU,
    input  logic [3:0]        RegNumber,
    input  logic [7:0]        pm_data,
    output logic [PC_W-1:0]   pm_addr,
    output logic [7:0]        Opcode,
    output logic              Zero_Carry,
    output logic [DATA_W-1:0] acc_out,
    output logic              acc_zero
);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b1000;
    localparam logic [3:0] ALU_SHR = 4'b1100;
    localparam logic [3:0] ALU_SHL = 4'b1101;

    logic [PC_W-1:0]            pc;
    logic [7:0]                 ir;
    logic [DATA_W-1:0]          acc;
    logic                       flag;
    logic [NREG-1:0][DATA_W-1:0] regs;

    logic [DATA_W-1:0] reg_rd, b_bus, imm, alu_res, acc_nxt;
    logic [DATA_W:0]   sum;
    logic              alu_c;

    // Reads are purely combinational, so a same-edge write is never seen by its own cycle.
    assign reg_rd = regs[RegNumber];
    assign b_bus  = DumpReg ? reg_rd : '0;
    assign imm    = DATA_W'(ir[3:0]);

    always_comb begin
        sum     = '0;
        alu_res = acc;
        alu_c   = 1'b0;
        case (SelALU)
            ALU_ADD: begin
                sum     = {1'b0, acc} + {1'b0, b_bus};
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            // Bit 8 of the 9-bit difference is the borrow (A < B).
            ALU_SUB: begin
                sum     = {1'b0, acc} - {1'b0, b_bus};
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            ALU_NOR: alu_res = ~(acc | b_bus);
            ALU_SHR: begin
                alu_res = acc >> 1;
                alu_c   = acc[0];
            end
            ALU_SHL: begin
                alu_res = acc << 1;
                alu_c   = acc[DATA_W-1];
            end
            default: begin
                alu_res = acc;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_comb begin
        acc_nxt = acc;
        case (SelAcc)
            2'b00:   acc_nxt = alu_res;
            2'b01:   acc_nxt = imm;
            2'b10:   acc_nxt = reg_rd;
            default: acc_nxt = acc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (LoadPC) begin
            pc <= SelPC ? PC_W'(imm) : PC_W'(reg_rd);
        end else if (IncPC) begin
            pc <= pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir <= '0;
        end else if (LoadIR) begin
            ir <= pm_data;
        end
    end

    // The flag only tracks ALU loads; immediate and register loads leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            flag <= 1'b0;
        end else if (LoadAcc) begin
            acc <= acc_nxt;
            if (SelAcc == 2'b00) flag <= alu_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '0;
        end else if (LoadReg) begin
            regs[RegNumber] <= acc;
        end
    end

    assign pm_addr    = pc;
    assign Opcode     = ir;
    assign Zero_Carry = flag;
    assign acc_out    = acc;
    assign acc_zero   = (acc == '0);
endmodule

// File: doc/acc_datapath.md
Name: acc_datapath

Overview:
- Datapath for the 8-bit accumulator CPU: program counter, instruction register, 16-entry register file, accumulator, ALU and carry flag.
- Consumes the per-cycle control strobes the sequencing controller issues and returns the opcode and Zero_Carry status it decodes.
- Sits between the program memory (address out, instruction byte in) and the controller.
- All state updates on the rising clk edge and are qualified only by the control strobes; the block has no FSM of its own.

Parameters:
- DATA_W, 8, accumulator/register/ALU width
- PC_W, 8, program counter and program-memory address width
- NREG, 16, register-file depth (indexed by RegNumber)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- LoadIR  in  1  IR <= pm_data
- IncPC  in  1  PC <= PC+1
- SelPC  in  1  jump source: 0 = Reg[RegNumber], 1 = immediate
- LoadPC  in  1  PC <= jump source
- LoadReg  in  1  Reg[RegNumber] <= ACC
- DumpReg  in  1  drive Reg[RegNumber] onto ALU B bus; 0 = B bus is 0
- LoadAcc  in  1  ACC <= source selected by SelAcc
- SelAcc  in  2  00 ALU result, 01 immediate, 10 Reg[RegNumber], 11 hold
- SelALU  in  4  ALU operation code
- RegNumber  in  4  register-file index
- pm_data  in  8  instruction byte from program memory at pm_addr
- pm_addr  out  PC_W  current PC
- Opcode  out  8  IR contents
- Zero_Carry  out  1  carry/borrow flag register
- acc_out  out  DATA_W  ACC contents
- acc_zero  out  1  combinational (ACC == 0)

Behaviour:
- Reset (reset=0, asynchronous): PC=0, IR=0, ACC=0, flag=0, all NREG registers=0. Outputs are therefore pm_addr=0, Opcode=0x00, Zero_Carry=0, acc_out=0, acc_zero=1. Reset asserted mid-cycle discards any pending update. The first update after deassertion occurs on the next rising edge with reset=1.
- Immediate: imm = zero-extended IR[3:0]. It is used for both SelAcc=01 and SelPC=1.
- PC:
  - LoadPC=1 has priority over IncPC.
  - With LoadPC=0 and IncPC=1, PC increments by 1 and wraps 0xFF -> 0x00.
  - Otherwise PC holds.
  - Latency 1 cycle; pm_addr reflects the new PC in the following cycle.
- IR: loads pm_data on LoadIR and otherwise holds. LoadIR in the same cycle as IncPC latches the byte at the old PC.
- ALU:
  - A = ACC; B = DumpReg ? Reg[RegNumber] : 0. All arithmetic is 9-bit and the result is the low 8 bits.
  - 0000 ADD: A+B; carry = bit 8.
  - 0001 SUB: A-B; carry = borrow (A<B).
  - 1000 NOR: ~(A|B); carry = 0.
  - 1100 SHR: A>>1, zero fill; carry = A[0].
  - 1101 SHL: A<<1, zero fill; carry = A[7].
  - Any other code passes A through with carry = 0.
- ACC/flag:
  - On LoadAcc with SelAcc=00: ACC <= ALU result and flag <= ALU carry.
  - On LoadAcc with SelAcc=01 or 10: ACC is loaded and the flag is unchanged.
  - SelAcc=11, or LoadAcc=0: ACC and flag hold.
- Register file:
  - Write on LoadReg at Reg[RegNumber].
  - Reads are combinational, with no write-through.
  - LoadReg and LoadAcc in the same cycle: the register gets the old ACC and ACC gets the new value.
  - LoadReg, with LoadAcc/SelAcc=10 on the same index: ACC gets the old register value.
  - LoadPC with SelPC=0 in the same cycle as LoadReg on the same index: PC gets the old register value.
- When all strobes are 0, all state holds. This is the idle/HALT condition.

Test Plan:
- Reset: drive arbitrary strobes, pulse reset=0 mid-cycle -> pm_addr=0, Opcode=0, acc_out=0, Zero_Carry=0, acc_zero=1 immediately; all registers read 0.
- Fetch/increment: pm_data=0xD5, LoadIR=1, IncPC=1 for one edge -> Opcode=0xD5, pm_addr=1. Then LoadAcc=1, SelAcc=01 -> acc_out=0x05.
- Arithmetic and carry:
  - ACC=0xF0, LoadReg to R3, then ACC=0x20.
  - ADD with R3 (DumpReg=1, RegNumber=3, SelALU=0000, LoadAcc=1) -> acc_out=0x10, Zero_Carry=1.
  - SUB 0x10-0xF0 -> acc_out=0x20, Zero_Carry=1.
  - NOR with DumpReg=0 on ACC=0xFF -> acc_out=0x00, acc_zero=1, Zero_Carry=0.
- Shifts: ACC=0x81, SHL -> 0x02 with carry 1; then SHR -> 0x01 with carry 0.
- Jumps:
  - R2=0x40; LoadPC=1, SelPC=0, RegNumber=2, IncPC=1 -> pm_addr=0x40 (LoadPC wins).
  - IR=0x7A; LoadPC=1, SelPC=1 -> pm_addr=0x0A.
  - PC=0xFF with IncPC -> pm_addr=0x00.
- Simultaneous access: ACC=0x11, R5=0x22; LoadReg=1 and LoadAcc=1, SelAcc=10, RegNumber=5 in one edge -> R5=0x11, acc_out=0x22.
